// File: rtl/traffic_light_monitor.sv
// Passive checker for a two-way traffic light controller: tracks the phase sequence,
// checks lamp encoding, conflicts and per-phase dwell time, and keeps sticky/counted errors.
module traffic_light_monitor #(
  parameter int unsigned PHASE_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ns_light,
  input  logic [2:0] ew_light,
  input  logic       clr,
  output logic [1:0] phase,
  output logic       phase_valid,
  output logic       err_encoding,
  output logic       err_conflict,
  output logic       err_sequence,
  output logic       err_timing,
  output logic [3:0] err_sticky,
  output logic [7:0] err_count
);

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [7:0] DWELL_REQ   = 8'(PHASE_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  dwell_q, dwell_d;
  logic        first_phase_q, first_phase_d;
  logic        enc_q, enc_d;
  logic        conf_q, conf_d;
  logic        seq_q, seq_d;
  logic        tim_q, tim_d;
  logic [3:0]  sticky_q, sticky_d;
  logic [7:0]  count_q, count_d;

  logic        ns_onehot, ew_onehot;
  logic        bad_encoding, is_conflict, is_all_red;
  logic [1:0]  obs_phase;
  logic [7:0]  dwell_inc;
  logic [3:0]  sticky_base;
  logic [7:0]  count_base;

  // Sample classification, highest priority first
  always_comb begin
    ns_onehot    = (ns_light == LAMP_RED) || (ns_light == LAMP_YELLOW) || (ns_light == LAMP_GREEN);
    ew_onehot    = (ew_light == LAMP_RED) || (ew_light == LAMP_YELLOW) || (ew_light == LAMP_GREEN);
    bad_encoding = !(ns_onehot && ew_onehot);
    is_conflict  = !bad_encoding && (ns_light != LAMP_RED) && (ew_light != LAMP_RED);
    is_all_red   = !bad_encoding && (ns_light == LAMP_RED) && (ew_light == LAMP_RED);
    if (ns_light == LAMP_GREEN)       obs_phase = 2'd0;
    else if (ns_light == LAMP_YELLOW) obs_phase = 2'd1;
    else if (ew_light == LAMP_GREEN)  obs_phase = 2'd2;
    else                              obs_phase = 2'd3;
    dwell_inc = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    dwell_d       = dwell_q;
    first_phase_d = first_phase_q;
    enc_d         = 1'b0;
    conf_d        = 1'b0;
    seq_d         = 1'b0;
    tim_d         = 1'b0;

    if (bad_encoding || is_conflict || is_all_red) begin
      enc_d   = bad_encoding;
      conf_d  = is_conflict;
      seq_d   = is_all_red;
      state_d = SYNC;
    end else if (state_q == SYNC) begin
      state_d       = TRACK;
      phase_d       = obs_phase;
      dwell_d       = 8'd1;
      first_phase_d = 1'b1;
    end else if (obs_phase == phase_q) begin
      dwell_d = dwell_inc;
      // Fires only on the sample that first exceeds the dwell, never again while held
      tim_d   = (dwell_q == DWELL_REQ) && (dwell_q != 8'hFF);
    end else if (obs_phase == phase_q + 2'd1) begin
      // A first phase may have been entered mid-way, so only overstay is an error
      tim_d         = first_phase_q ? (dwell_q > DWELL_REQ) : (dwell_q != DWELL_REQ);
      phase_d       = obs_phase;
      dwell_d       = 8'd1;
      first_phase_d = 1'b0;
    end else begin
      seq_d         = 1'b1;
      phase_d       = obs_phase;
      dwell_d       = 8'd1;
      first_phase_d = 1'b1;
    end

    sticky_base = clr ? 4'd0 : sticky_q;
    count_base  = clr ? 8'd0 : count_q;
    sticky_d    = sticky_base | {tim_d, seq_d, conf_d, enc_d};
    count_d     = count_base;
    if ((tim_d || seq_d || conf_d || enc_d) && (count_base != 8'hFF)) begin
      count_d = count_base + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SYNC;
      phase_q       <= 2'd0;
      dwell_q       <= 8'd0;
      first_phase_q <= 1'b1;
      enc_q         <= 1'b0;
      conf_q        <= 1'b0;
      seq_q         <= 1'b0;
      tim_q         <= 1'b0;
      sticky_q      <= 4'd0;
      count_q       <= 8'd0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      dwell_q       <= dwell_d;
      first_phase_q <= first_phase_d;
      enc_q         <= enc_d;
      conf_q        <= conf_d;
      seq_q         <= seq_d;
      tim_q         <= tim_d;
      sticky_q      <= sticky_d;
      count_q       <= count_d;
    end
  end

  assign phase        = phase_q;
  assign phase_valid  = (state_q == TRACK);
  assign err_encoding = enc_q;
  assign err_conflict = conf_q;
  assign err_sequence = seq_q;
  assign err_timing   = tim_q;
  assign err_sticky   = sticky_q;
  assign err_count    = count_q;

endmodule
